// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if
//   Bundles the two requester handshakes and the transmitter parallel-load
//   port of the UART transmit scheduler.
//   master : the surrounding system (requesters, transmitter Busy flag)
//   slave  : the scheduler itself
//   Signals:
//     reqN_valid/reqN_data[15:0]/reqN_two : frame offered by requester N
//     reqN_ready                          : combinational accept from scheduler
//     tx_p_data[7:0]/tx_data_valid        : byte and load pulse to transmitter
//     tx_busy                             : transmitter Busy
//     sched_busy/owner/err_to             : scheduler status
interface uart_tx_sched_if;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_two;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_two;
  logic        req1_ready;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid;
  logic        tx_busy;
  logic        sched_busy;
  logic        owner;
  logic        err_to;

  modport master (
    output req0_valid, req0_data, req0_two,
    output req1_valid, req1_data, req1_two,
    output tx_busy,
    input  req0_ready, req1_ready,
    input  tx_p_data, tx_data_valid, sched_busy, owner, err_to
  );

  modport slave (
    input  req0_valid, req0_data, req0_two,
    input  req1_valid, req1_data, req1_two,
    input  tx_busy,
    output req0_ready, req1_ready,
    output tx_p_data, tx_data_valid, sched_busy, owner, err_to
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Two-requester transmit scheduler in front of the UART transmitter.
//   Accepts 1- or 2-byte frames, arbitrates between the two sources and
//   feeds one byte at a time into the transmitter parallel-load port,
//   pacing each load on the transmitter Busy flag. A load that never sees
//   Busy rise within BUSY_TO cycles aborts the rest of the frame.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : uart_tx_sched_if.slave (requesters, transmitter, status)
//   Parameters:
//     BUSY_TO : busy-rise timeout in cycles, 2..255
//   Build option:
//     UART_TX_SCHED_RR_EN : round-robin arbitration when defined,
//                           fixed priority (req0 wins) otherwise.
module uart_tx_sched #(
  parameter int BUSY_TO = 16
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

  localparam logic [7:0] TO_LAST = 8'(BUSY_TO - 1);

  state_t      state_reg;
  logic [7:0]  hold_hi_reg;   // second byte of the captured frame
  logic        hold_two_reg;
  logic        index_reg;
  logic [7:0]  cnt_reg;
  logic [7:0]  tx_p_data_reg;
  logic        tx_data_valid_reg;
  logic        sched_busy_reg;
  logic        owner_reg;
  logic        err_to_reg;

  logic        grant0;
  logic        grant1;
  logic        can_accept;
  logic        accept0;
  logic        accept1;
  logic [15:0] acc_data;
  logic        acc_two;

`ifdef UART_TX_SCHED_RR_EN
  // Index of the requester that wins the next contested grant.
  logic rr_ptr_reg;

  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~rr_ptr_reg);
  assign grant1 = bus.req1_valid & (~bus.req0_valid |  rr_ptr_reg);

  // Favour whoever was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= 1'b0;
    end else if (accept0 | accept1) begin
      rr_ptr_reg <= accept0;
    end
  end
`else
  assign grant0 = bus.req0_valid;
  assign grant1 = bus.req1_valid & ~bus.req0_valid;
`endif

  // rst_n is part of the ready term so no transfer is signalled while the
  // design is held in reset.
  assign can_accept     = (state_reg == IDLE) & ~bus.tx_busy & rst_n;
  assign accept0        = grant0 & can_accept;
  assign accept1        = grant1 & can_accept;
  assign bus.req0_ready = accept0;
  assign bus.req1_ready = accept1;

  assign acc_data = accept1 ? bus.req1_data : bus.req0_data;
  assign acc_two  = accept1 ? bus.req1_two  : bus.req0_two;

  // Load outputs are registered on entry to LOAD so the pulse lines up
  // with the LOAD cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      hold_hi_reg       <= 8'h00;
      hold_two_reg      <= 1'b0;
      index_reg         <= 1'b0;
      cnt_reg           <= 8'h00;
      tx_p_data_reg     <= 8'h00;
      tx_data_valid_reg <= 1'b0;
      sched_busy_reg    <= 1'b0;
      owner_reg         <= 1'b0;
      err_to_reg        <= 1'b0;
    end else begin
      tx_data_valid_reg <= 1'b0;
      err_to_reg        <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept0 | accept1) begin
            hold_hi_reg       <= acc_data[15:8];
            hold_two_reg      <= acc_two;
            owner_reg         <= accept1;
            index_reg         <= 1'b0;
            tx_p_data_reg     <= acc_data[7:0];
            tx_data_valid_reg <= 1'b1;
            sched_busy_reg    <= 1'b1;
            state_reg         <= LOAD;
          end
        end
        LOAD: begin
          cnt_reg   <= 8'h00;
          state_reg <= WAIT_HI;
        end
        WAIT_HI: begin
          if (bus.tx_busy) begin
            state_reg <= WAIT_LO;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
            // Counter reaches BUSY_TO on this edge: abort the frame.
            if (cnt_reg == TO_LAST) begin
              err_to_reg     <= 1'b1;
              sched_busy_reg <= 1'b0;
              state_reg      <= IDLE;
            end
          end
        end
        WAIT_LO: begin
          if (!bus.tx_busy) begin
            if (hold_two_reg && !index_reg) begin
              index_reg         <= 1'b1;
              tx_p_data_reg     <= hold_hi_reg;
              tx_data_valid_reg <= 1'b1;
              state_reg         <= LOAD;
            end else begin
              sched_busy_reg <= 1'b0;
              state_reg      <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.tx_p_data     = tx_p_data_reg;
  assign bus.tx_data_valid = tx_data_valid_reg;
  assign bus.sched_busy    = sched_busy_reg;
  assign bus.owner         = owner_reg;
  assign bus.err_to        = err_to_reg;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Two-requester transmit scheduler in front of the UART transmitter. It accepts 1- or 2-byte frames from two independent sources, such as the system controller's register-read response and its ALU result. It arbitrates between them and feeds one byte at a time into the transmitter's parallel-load port, pacing each load on the transmitter's busy flag. It is the only driver of the transmitter's data/valid inputs in the system.

## Interface
- BUSY_TO, default 16: maximum cycles to wait for tx_busy to rise after a load pulse before aborting the frame; range 2..255.
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has a frame; held with data until accepted.
- req0_data  input  16  frame bytes: [7:0] sent first, [15:8] second.
- req0_two  input  1  1: frame is 2 bytes; 0: only [7:0] is sent.
- req0_ready  output  1  combinational accept; transfer occurs on an edge where valid and ready are both high.
- req1_valid, req1_data[15:0], req1_two, req1_ready: same as requester 0.
- tx_p_data  output  8  byte to transmitter P_DATA, registered.
- tx_data_valid  output  1  one-cycle load pulse to transmitter Data_Valid, registered.
- tx_busy  input  1  transmitter Busy.
- sched_busy  output  1  high from acceptance until the last byte's tx_busy falls.
- owner  output  1  index of the requester whose frame is in flight (valid while sched_busy).
- err_to  output  1  one-cycle pulse on busy-rise timeout.

## Operation
- States: IDLE, LOAD, WAIT_HI, WAIT_LO.
- IDLE:
  - readyN = grantN & reqN_valid & ~tx_busy & rst_n; at most one ready is high.
  - On transfer, capture data and the two flag into holding registers, set owner, byte index = 0, go to LOAD.
- LOAD:
  - Register tx_p_data = holding byte[index] and tx_data_valid = 1 for exactly one cycle.
  - Clear the timeout counter; go to WAIT_HI.
- WAIT_HI:
  - tx_busy = 1: go to WAIT_LO.
  - Otherwise increment the counter. When the counter reaches BUSY_TO, pulse err_to, drop the rest of the frame, and go to IDLE.
- WAIT_LO:
  - tx_busy = 0 and two-byte frame with index 0: index = 1, go to LOAD.
  - tx_busy = 0 otherwise: go to IDLE.
- tx_p_data holds its last value outside LOAD; tx_data_valid is 0 outside LOAD.
- Arbitration:
  - Only one valid: it is granted.
  - Both valid: granted per Configuration.
- Requester data changes while not accepted are ignored until transfer. Captured data is never affected by later requester changes.
- Reset, asynchronous, any state: state = IDLE, tx_p_data = 0, tx_data_valid = 0, sched_busy = 0, owner = 0, err_to = 0, index = 0, counter = 0, RR pointer = favour req0. Readies are low while rst_n is low. A frame in progress is discarded and not resumed.

## Timing
- Accept edge at cycle T: tx_data_valid is high during T+1 (LOAD output registered at entry).
- Byte 2 load pulse: the cycle after the first cycle tx_busy is sampled low in WAIT_LO.
- Back-to-back frames: readiness returns in the cycle after WAIT_LO exits. The minimum gap from a frame's final busy-fall to the next load pulse is 2 cycles.
- tx_busy sampled high in IDLE blocks acceptance; ready stays low.
- err_to is asserted in the cycle after the counter hits BUSY_TO. sched_busy falls in the same cycle.
- sched_busy is high in LOAD, WAIT_HI and WAIT_LO; it is low in IDLE.

## Configuration
- UART_TX_SCHED_RR_EN defined: round-robin. On a contested grant, the requester not granted last wins. The pointer updates on every transfer.
- Undefined: fixed priority, req0 always wins when both are valid. The pointer logic is absent.

## Test plan
- Single byte: req0 valid, data 16'h00A5, two = 0; tx_busy model rises 1 cycle after the pulse and stays 11 cycles.
  - req0_ready high 1 cycle.
  - One pulse with tx_p_data = 8'hA5.
  - sched_busy falls when busy falls.
- Two bytes: req1 data 16'h3C7E, two = 1.
  - Pulses with 8'h7E, then 8'h3C, the second one cycle after the first busy falls.
  - owner = 1 throughout.
- Contention: req0 and req1 both held valid with two frames each.
  - RR_EN: grants alternate 0, 1, 0, 1.
  - Without it: 0, 0, then 1, 1.
- Timeout: tx_busy tied 0 after the pulse, BUSY_TO = 16.
  - err_to pulses 17 cycles after the LOAD cycle.
  - Second byte never sent; state returns to IDLE and accepts again.
- Reset mid-frame: assert rst_n low during WAIT_LO of byte 1 of a 2-byte frame.
  - All outputs go to 0 immediately.
  - After release, no byte-2 pulse.
  - A new req0 frame transmits normally.
- Busy at idle: tx_busy forced high with req0 valid.
  - req0_ready stays 0 until tx_busy is low; then accepted.
